mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Brief    : Single-outstanding load/store unit. It checks alignment, builds
//             the byte-lane strobe and data for the data bus, and formats
//             load data with sign or zero extension. A flush that arrives
//             while the bus is busy drains the transaction, which is never
//             abandoned. ADDR_W must be at least 32, because in_addr[31]
//             drives out_skip.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_write,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              flush,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [1:0]        dreq_size,
  output logic [7:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_data,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data,
  output logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_misaligned,
  output logic              out_skip
);

  localparam int c_LANE_W = $clog2(DATA_W / 8);
  localparam bit c_NARROW = (DATA_W == 32);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_size;
  logic                r_signed;
  logic                r_write;
  logic [7:0]          r_strobe;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_misaligned;
  logic                r_skip;

  logic [c_LANE_W-1:0] w_lane;
  logic [c_LANE_W-1:0] w_align_mask;
  logic                w_misaligned;
  logic [3:0]          w_bytes;
  logic [7:0]          w_byte_mask;
  logic [7:0]          w_strobe;
  logic [DATA_W-1:0]   w_wdata_sh;
  logic [c_LANE_W-1:0] w_rlane;
  logic [DATA_W-1:0]   w_rshift;
  logic [6:0]          w_nbits;
  logic [DATA_W-1:0]   w_keep;
  logic                w_sign;
  logic [DATA_W-1:0]   w_fmt;

  // Request decode: alignment check, strobe mask and store data placement
  always_comb begin
    w_lane       = in_addr[c_LANE_W-1:0];
    w_align_mask = c_LANE_W'((4'd1 << in_size) - 4'd1);
    // An 8-byte access can never fit a 32-bit bus, even at lane 0
    w_misaligned = (|(w_lane & w_align_mask)) || (c_NARROW && (in_size == 2'd3));
    w_bytes      = 4'd1 << in_size;
    w_byte_mask  = 8'((16'd1 << w_bytes) - 16'd1);
    w_strobe     = w_byte_mask << w_lane;
    w_wdata_sh   = in_wdata << {w_lane, 3'b000};
  end

  // Load formatting: right-align the addressed lanes, keep the access width, extend
  always_comb begin
    w_rlane  = r_addr[c_LANE_W-1:0];
    w_rshift = dresp_data >> {w_rlane, 3'b000};
    w_nbits  = 7'd8 << r_size;
    // A shift by the full bus width yields zero, so keep covers every bit then
    w_keep   = ~({DATA_W{1'b1}} << w_nbits);
    case (r_size)
      2'd0:    w_sign = w_rshift[7];
      2'd1:    w_sign = w_rshift[15];
      2'd2:    w_sign = w_rshift[31];
      default: w_sign = w_rshift[DATA_W-1];
    endcase
    w_fmt = (w_rshift & w_keep) | ((r_signed && w_sign) ? ~w_keep : '0);
  end

  // Control FSM together with the latched request and completion registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_size       <= '0;
      r_signed     <= 1'b0;
      r_write      <= 1'b0;
      r_strobe     <= '0;
      r_data       <= '0;
      r_rdata      <= '0;
      r_misaligned <= 1'b0;
      r_skip       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && !flush) begin
            r_addr       <= in_addr;
            r_size       <= in_size;
            r_signed     <= in_signed;
            r_write      <= in_write;
            r_misaligned <= w_misaligned;
            r_skip       <= ~in_addr[31] & ~w_misaligned;
            r_rdata      <= '0;
            if (w_misaligned) begin
              r_strobe <= '0;
              r_data   <= '0;
              r_state  <= DONE;
            end else begin
              r_strobe <= in_write ? w_strobe : 8'h00;
              r_data   <= in_write ? w_wdata_sh : '0;
              r_state  <= BUS;
            end
          end
        end
        BUS: begin
          if (dresp_data_ok) begin
            if (flush) begin
              r_state <= IDLE;
            end else begin
              r_rdata <= r_write ? '0 : w_fmt;
              r_state <= DONE;
            end
          end else if (flush) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (dresp_data_ok) begin
            r_state <= IDLE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign dreq_valid     = (r_state == BUS) || (r_state == DRAIN);
  assign dreq_addr      = r_addr;
  assign dreq_size      = r_size;
  assign dreq_strobe    = r_strobe;
  assign dreq_data      = r_data;
  assign stall          = ((r_state == IDLE) && in_valid && !flush) ||
                          (r_state == BUS) || (r_state == DRAIN);
  assign out_valid      = (r_state == DONE) && !flush;
  assign out_rdata      = r_rdata;
  assign out_misaligned = r_misaligned;
  assign out_skip       = r_skip;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Brief    : Randomized and directed bench for a 64-bit and a 32-bit
//             instance, compared against a byte-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid64, in_valid32;
  logic        in_write;
  logic [63:0] in_addr;
  logic [1:0]  in_size;
  logic        in_signed;
  logic [63:0] in_wdata;
  logic        flush;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  logic        d64_dreq_valid, d32_dreq_valid;
  logic [63:0] d64_dreq_addr, d32_dreq_addr;
  logic [1:0]  d64_dreq_size, d32_dreq_size;
  logic [7:0]  d64_dreq_strobe, d32_dreq_strobe;
  logic [63:0] d64_dreq_data;
  logic [31:0] d32_dreq_data;
  logic        d64_stall, d32_stall;
  logic        d64_out_valid, d32_out_valid;
  logic [63:0] d64_out_rdata;
  logic [31:0] d32_out_rdata;
  logic        d64_out_mis, d32_out_mis;
  logic        d64_out_skip, d32_out_skip;

  // Snapshot of the selected instance, widened to 64 bits
  logic        s_dreq_valid, s_stall, s_out_valid, s_mis, s_skip;
  logic [63:0] s_addr, s_data, s_rdata;
  logic [1:0]  s_size;
  logic [7:0]  s_strobe;

  // Last observed values of the most recent operation
  logic [63:0] l_rdata, l_data;
  logic [7:0]  l_strobe;
  logic        l_mis, l_skip;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(64), .ADDR_W(64)) u_dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid64), .in_write(in_write),
    .in_addr(in_addr), .in_size(in_size), .in_signed(in_signed),
    .in_wdata(in_wdata), .flush(flush),
    .dreq_valid(d64_dreq_valid), .dreq_addr(d64_dreq_addr), .dreq_size(d64_dreq_size),
    .dreq_strobe(d64_dreq_strobe), .dreq_data(d64_dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .stall(d64_stall), .out_valid(d64_out_valid), .out_rdata(d64_out_rdata),
    .out_misaligned(d64_out_mis), .out_skip(d64_out_skip)
  );

  mem_access_unit #(.DATA_W(32), .ADDR_W(64)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid32), .in_write(in_write),
    .in_addr(in_addr), .in_size(in_size), .in_signed(in_signed),
    .in_wdata(in_wdata[31:0]), .flush(flush),
    .dreq_valid(d32_dreq_valid), .dreq_addr(d32_dreq_addr), .dreq_size(d32_dreq_size),
    .dreq_strobe(d32_dreq_strobe), .dreq_data(d32_dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data[31:0]),
    .stall(d32_stall), .out_valid(d32_out_valid), .out_rdata(d32_out_rdata),
    .out_misaligned(d32_out_mis), .out_skip(d32_out_skip)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic snap(input bit w32);
    s_dreq_valid = w32 ? d32_dreq_valid  : d64_dreq_valid;
    s_addr       = w32 ? d32_dreq_addr   : d64_dreq_addr;
    s_size       = w32 ? d32_dreq_size   : d64_dreq_size;
    s_strobe     = w32 ? d32_dreq_strobe : d64_dreq_strobe;
    s_data       = w32 ? {32'd0, d32_dreq_data} : d64_dreq_data;
    s_stall      = w32 ? d32_stall       : d64_stall;
    s_out_valid  = w32 ? d32_out_valid   : d64_out_valid;
    s_rdata      = w32 ? {32'd0, d32_out_rdata} : d64_out_rdata;
    s_mis        = w32 ? d32_out_mis     : d64_out_mis;
    s_skip       = w32 ? d32_out_skip    : d64_out_skip;
  endtask

  task automatic set_valid(input bit w32, input logic v);
    if (w32) in_valid32 = v;
    else     in_valid64 = v;
  endtask

  // Byte-level reference: bus of nb bytes, access of 2**size bytes
  function automatic void model(input bit w32, input logic wr, input logic [63:0] addr,
                                input logic [1:0] size, input logic sgn,
                                input logic [63:0] wd, input logic [63:0] resp,
                                output logic mis, output logic [7:0] strb,
                                output logic [63:0] data, output logic [63:0] rdata,
                                output logic skip);
    int nb, lane, bytes, bits;
    logic [127:0] wmask, v;
    nb    = w32 ? 4 : 8;
    lane  = int'(addr[2:0]) % nb;
    bytes = 1 << size;
    bits  = 8 * bytes;
    wmask = (128'd1 << (8 * nb)) - 128'd1;
    mis   = ((lane % bytes) != 0) || (bytes > nb);
    strb  = wr ? 8'(((1 << bytes) - 1) << lane) : 8'h00;
    v     = ({64'd0, wd} & wmask) << (8 * lane);
    data  = wr ? 64'(v & wmask) : 64'd0;
    v     = (({64'd0, resp} & wmask) >> (8 * lane)) & ((128'd1 << bits) - 128'd1);
    if (sgn && v[bits-1]) v = v - (128'd1 << bits);
    rdata = wr ? 64'd0 : 64'(v & wmask);
    skip  = !addr[31] && !mis;
  endfunction

  // One operation: flush_at = BUS cycle (1..nwait) carrying flush, 0 for none
  task automatic run_op(input bit w32, input logic wr, input logic [63:0] addr,
                        input logic [1:0] size, input logic sgn, input logic [63:0] wd,
                        input logic [63:0] resp, input int nwait, input int flush_at,
                        input bit flush_done);
    logic       e_mis, e_skip;
    logic [7:0] e_strb;
    logic [63:0] e_data, e_rdata;
    bit flushed;
    model(w32, wr, addr, size, sgn, wd, resp, e_mis, e_strb, e_data, e_rdata, e_skip);
    flushed = 1'b0;
    @(negedge clk);
    in_write = wr; in_addr = addr; in_size = size; in_signed = sgn; in_wdata = wd;
    flush = 1'b0; dresp_data_ok = 1'b0;
    set_valid(w32, 1'b1);
    #1 snap(w32);
    chk("accept_stall", 64'(s_stall), 64'd1);
    chk("accept_dreq_valid", 64'(s_dreq_valid), 64'd0);
    chk("accept_out_valid", 64'(s_out_valid), 64'd0);
    if (e_mis) begin
      @(negedge clk);
      set_valid(w32, 1'b0);
      flush = flush_done;
      #1 snap(w32);
      chk("mis_out_valid", 64'(s_out_valid), 64'(!flush_done));
      chk("mis_flag", 64'(s_mis), 64'd1);
      chk("mis_skip", 64'(s_skip), 64'd0);
      chk("mis_stall", 64'(s_stall), 64'd0);
      chk("mis_dreq_valid", 64'(s_dreq_valid), 64'd0);
      l_mis = s_mis; l_skip = s_skip; l_rdata = s_rdata;
    end else begin
      for (int c = 1; c <= nwait; c++) begin
        @(negedge clk);
        flush = 1'b0; dresp_data_ok = 1'b0;
        dresp_data = {$urandom, $urandom};
        #1 snap(w32);
        chk("bus_dreq_valid", 64'(s_dreq_valid), 64'd1);
        chk("bus_stall", 64'(s_stall), 64'd1);
        chk("bus_out_valid", 64'(s_out_valid), 64'd0);
        chk("bus_addr", s_addr, addr);
        chk("bus_size", 64'(s_size), 64'(size));
        chk("bus_strobe", 64'(s_strobe), 64'(e_strb));
        chk("bus_data", s_data, e_data);
        l_strobe = s_strobe; l_data = s_data;
        if (c == flush_at) begin
          flush = 1'b1; set_valid(w32, 1'b0); flushed = 1'b1;
        end
        if (c == nwait) begin
          dresp_data_ok = 1'b1; dresp_data = resp;
        end
      end
      @(negedge clk);
      dresp_data_ok = 1'b0;
      dresp_data = {$urandom, $urandom};
      set_valid(w32, 1'b0);
      flush = flushed ? 1'b0 : flush_done;
      #1 snap(w32);
      chk("done_stall", 64'(s_stall), 64'd0);
      chk("done_dreq_valid", 64'(s_dreq_valid), 64'd0);
      if (flushed) begin
        chk("flushed_out_valid", 64'(s_out_valid), 64'd0);
      end else begin
        chk("done_out_valid", 64'(s_out_valid), 64'(!flush_done));
        chk("done_mis", 64'(s_mis), 64'd0);
        chk("done_skip", 64'(s_skip), 64'(e_skip));
        chk("done_rdata", s_rdata, e_rdata);
        l_rdata = s_rdata; l_mis = s_mis; l_skip = s_skip;
      end
    end
    @(negedge clk);
    flush = 1'b0;
    #1 snap(w32);
    chk("after_out_valid", 64'(s_out_valid), 64'd0);
    chk("after_dreq_valid", 64'(s_dreq_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] a;
    logic [1:0]  sz;
    int nw, fm, fa;
    bit w32, fd;
    reset = 1'b1; in_valid64 = 1'b0; in_valid32 = 1'b0; in_write = 1'b0;
    in_addr = '0; in_size = '0; in_signed = 1'b0; in_wdata = '0; flush = 1'b0;
    dresp_data_ok = 1'b0; dresp_data = '0;
    #3;
    chk("rst_dreq_valid", 64'(d64_dreq_valid), 64'd0);
    chk("rst_out_valid", 64'(d64_out_valid), 64'd0);
    chk("rst_stall", 64'(d64_stall), 64'd0);
    chk("rst_rdata", d64_out_rdata, 64'd0);
    chk("rst_strobe", 64'(d64_dreq_strobe), 64'd0);
    chk("rst32_dreq_valid", 64'(d32_dreq_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Signed halfword load, lane 6
    run_op(0, 0, 64'h8000_0006, 2'd1, 1, 64'd0, 64'hBEEF_0000_0000_0000, 2, 0, 0);
    chk("d36_rdata", l_rdata, 64'hFFFF_FFFF_FFFF_BEEF);
    chk("d36_skip", 64'(l_skip), 64'd0);
    // Word store into the upper half
    run_op(0, 1, 64'h8000_0004, 2'd2, 0, 64'h1122_3344, 64'h0123_4567_89AB_CDEF, 3, 0, 0);
    chk("d37_strobe", 64'(l_strobe), 64'hF0);
    chk("d37_data", l_data, 64'h1122_3344_0000_0000);
    chk("d37_rdata", l_rdata, 64'd0);
    // Misaligned word load
    run_op(0, 0, 64'h8000_0003, 2'd2, 0, 64'd0, 64'd0, 1, 0, 0);
    chk("d38_mis", 64'(l_mis), 64'd1);
    // Flush in BUS cycle 1, data_ok in cycle 3
    run_op(0, 0, 64'h8000_0008, 2'd3, 0, 64'd0, 64'hDEAD_BEEF_0000_1111, 3, 1, 0);
    // Flush together with data_ok in BUS
    run_op(0, 0, 64'h0000_0010, 2'd2, 1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 2, 0);
    // Flush while in DONE suppresses out_valid
    run_op(0, 0, 64'h0000_0020, 2'd0, 0, 64'd0, 64'h55, 1, 0, 1);
    // 32-bit bus: doubleword is always misaligned; unsigned byte load
    run_op(1, 0, 64'h0000_0000, 2'd3, 0, 64'd0, 64'd0, 1, 0, 0);
    chk("d40_mis", 64'(l_mis), 64'd1);
    run_op(1, 0, 64'h0000_0010, 2'd0, 0, 64'd0, 64'h0000_0080, 1, 0, 0);
    chk("d40_rdata", l_rdata, 64'h80);
    chk("d40_skip", 64'(l_skip), 64'd1);

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    in_addr = 64'h40; in_size = 2'd2; in_write = 1'b0; in_valid64 = 1'b1; flush = 1'b1;
    #1 chk("idle_flush_stall", 64'(d64_stall), 64'd0);
    @(negedge clk);
    in_valid64 = 1'b0; flush = 1'b0;
    #1 chk("idle_flush_dreq_valid", 64'(d64_dreq_valid), 64'd0);
    chk("idle_flush_out_valid", 64'(d64_out_valid), 64'd0);

    // Reset in the middle of BUS, then a late data_ok
    @(negedge clk);
    in_addr = 64'h8000_0000; in_size = 2'd3; in_write = 1'b1; in_wdata = 64'hA5A5;
    in_valid64 = 1'b1;
    @(negedge clk);
    #1 chk("rbus_dreq_valid", 64'(d64_dreq_valid), 64'd1);
    #1 reset = 1'b1; in_valid64 = 1'b0;
    #1 chk("rbus_drop_valid", 64'(d64_dreq_valid), 64'd0);
    chk("rbus_stall", 64'(d64_stall), 64'd0);
    chk("rbus_strobe", 64'(d64_dreq_strobe), 64'd0);
    chk("rbus_data", d64_dreq_data, 64'd0);
    chk("rbus_addr", d64_dreq_addr, 64'd0);
    @(negedge clk);
    reset = 1'b0; dresp_data_ok = 1'b1; dresp_data = 64'h1234;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    #1 chk("late_ok_out_valid", 64'(d64_out_valid), 64'd0);
    chk("late_ok_dreq_valid", 64'(d64_dreq_valid), 64'd0);
    @(negedge clk);
    #1 chk("late_ok_out_valid2", 64'(d64_out_valid), 64'd0);

    // Randomized operations on both instances
    for (int i = 0; i < 300; i++) begin
      w32 = ($urandom_range(0, 2) == 0);
      a   = {$urandom, $urandom};
      sz  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~3'((1 << sz) - 1);
      nw  = $urandom_range(1, 4);
      fm  = $urandom_range(0, 9);
      fa  = (fm == 6 || fm == 7) ? $urandom_range(1, nw) : 0;
      fd  = (fm == 8);
      run_op(w32, 1'($urandom), a, sz, 1'($urandom), {$urandom, $urandom},
             {$urandom, $urandom}, nw, fa, fd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
